// File: rtl/batrider_pal_arb.sv
// Palette RAM arbiter: video lookups have hard priority, CPU writes are posted through a FIFO,
// and CPU reads are ordered behind pending writes. Define BATRIDER_PAL_CPU_RD_EN to enable RAM readback.
module batrider_pal_arb #(
  parameter int unsigned   AW          = 11,
  parameter int unsigned   DW          = 16,
  parameter int unsigned   WFIFO_DEPTH = 4,
  parameter logic [DW-1:0] RD_FILL     = DW'(16'hFFFF)
) (
  input  logic          CLK,
  input  logic          RESET,
  input  logic          PIXEL_CEN,
  input  logic [AW-1:0] PIXEL,
  output logic [DW-1:0] VID_DATA,
  output logic          VID_VALID,
  input  logic          CPU_CS,
  input  logic          CPU_WE,
  input  logic [AW-1:0] CPU_ADDR,
  input  logic [DW-1:0] CPU_DIN,
  input  logic [1:0]    CPU_DSN,
  output logic [DW-1:0] CPU_DOUT,
  output logic          CPU_OK,
  output logic [AW-1:0] RAM_ADDR,
  output logic [DW-1:0] RAM_DOUT,
  output logic [1:0]    RAM_WE,
  input  logic [DW-1:0] RAM_DIN
);

  localparam int unsigned PW = $clog2(WFIFO_DEPTH);
  localparam int unsigned CW = PW + 1;

`ifdef BATRIDER_PAL_CPU_RD_EN
  typedef enum logic [2:0] {S_IDLE, S_RD_WAIT, S_RD_ISSUE, S_RD_CAP, S_ACK_LOW} state_e;
`else
  typedef enum logic [0:0] {S_IDLE, S_ACK_LOW} state_e;
`endif

  state_e state_q, state_d;

  logic [AW-1:0] fifo_addr_q [WFIFO_DEPTH];
  logic [DW-1:0] fifo_data_q [WFIFO_DEPTH];
  logic [1:0]    fifo_be_q   [WFIFO_DEPTH];
  logic [PW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;

  logic          ok_q, ok_d;
  logic [DW-1:0] cpu_dout_q, cpu_dout_d;
  logic          vid_pend_q, vid_pend_d;
  logic          vid_valid_q, vid_valid_d;
  logic [DW-1:0] vid_data_q, vid_data_d;

  logic fifo_empty, fifo_full, cpu_req, wr_null, pop, push, write_ack;

  assign fifo_empty = (count_q == '0);
  assign fifo_full  = (count_q == CW'(WFIFO_DEPTH));
  assign cpu_req    = CPU_CS && (state_q == S_IDLE);
  assign wr_null    = (CPU_DSN == 2'b11);
  assign write_ack  = cpu_req && CPU_WE && (wr_null || !fifo_full || pop);
  assign push       = !RESET && write_ack && !wr_null;

  // RAM port owner: video first, then a pending CPU read issue, then the FIFO head.
  always_comb begin
    RAM_ADDR = '0;
    RAM_DOUT = '0;
    RAM_WE   = 2'b00;
    pop      = 1'b0;
    if (!RESET) begin
      if (PIXEL_CEN) begin
        RAM_ADDR = PIXEL;
      end
`ifdef BATRIDER_PAL_CPU_RD_EN
      else if (state_q == S_RD_ISSUE) begin
        RAM_ADDR = CPU_ADDR;
      end
`endif
      else if (!fifo_empty) begin
        RAM_ADDR = fifo_addr_q[rd_ptr_q];
        RAM_DOUT = fifo_data_q[rd_ptr_q];
        RAM_WE   = fifo_be_q[rd_ptr_q];
        pop      = 1'b1;
      end
    end
  end

  always_comb begin
    wr_ptr_d    = wr_ptr_q + PW'(push);
    rd_ptr_d    = rd_ptr_q + PW'(pop);
    count_d     = count_q + CW'(push) - CW'(pop);
    vid_pend_d  = PIXEL_CEN;
    vid_valid_d = vid_pend_q;
    vid_data_d  = vid_pend_q ? RAM_DIN : vid_data_q;
  end

  // FSM state register
  always_ff @(posedge CLK) begin
    if (RESET) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  // FSM next state
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (cpu_req) begin
          if (CPU_WE) begin
            if (write_ack) state_d = S_ACK_LOW;
          end else begin
`ifdef BATRIDER_PAL_CPU_RD_EN
            state_d = S_RD_WAIT;
`else
            state_d = S_ACK_LOW;
`endif
          end
        end
      end
`ifdef BATRIDER_PAL_CPU_RD_EN
      S_RD_WAIT:  if (fifo_empty && !PIXEL_CEN) state_d = S_RD_ISSUE;
      S_RD_ISSUE: state_d = PIXEL_CEN ? S_RD_WAIT : S_RD_CAP;
      S_RD_CAP:   state_d = S_ACK_LOW;
`endif
      S_ACK_LOW:  if (!CPU_CS) state_d = S_IDLE;
      default:    state_d = S_IDLE;
    endcase
  end

  // FSM outputs
  always_comb begin
    ok_d       = 1'b0;
    cpu_dout_d = cpu_dout_q;
    case (state_q)
      S_IDLE: begin
        if (cpu_req) begin
          if (CPU_WE) ok_d = write_ack;
`ifndef BATRIDER_PAL_CPU_RD_EN
          else begin
            ok_d       = 1'b1;
            cpu_dout_d = RD_FILL;
          end
`endif
        end
      end
`ifdef BATRIDER_PAL_CPU_RD_EN
      S_RD_CAP: begin
        ok_d       = 1'b1;
        cpu_dout_d = RAM_DIN;
      end
`endif
      default: ;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      ok_q        <= 1'b0;
      cpu_dout_q  <= '0;
      vid_pend_q  <= 1'b0;
      vid_valid_q <= 1'b0;
      vid_data_q  <= '0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      ok_q        <= ok_d;
      cpu_dout_q  <= cpu_dout_d;
      vid_pend_q  <= vid_pend_d;
      vid_valid_q <= vid_valid_d;
      vid_data_q  <= vid_data_d;
    end
  end

  // FIFO storage needs no reset; occupancy is tracked by the pointers
  always_ff @(posedge CLK) begin
    if (push) begin
      fifo_addr_q[wr_ptr_q] <= CPU_ADDR;
      fifo_data_q[wr_ptr_q] <= CPU_DIN;
      fifo_be_q[wr_ptr_q]   <= ~CPU_DSN;
    end
  end

  assign VID_DATA  = vid_data_q;
  assign VID_VALID = vid_valid_q;
  assign CPU_DOUT  = cpu_dout_q;
  assign CPU_OK    = ok_q;

endmodule

// File: tb/tb_batrider_pal_arb.sv
// Directed testbench for batrider_pal_arb with a byte-writable, 1-cycle-latency palette RAM model.
`timescale 1ns/1ps
module tb_batrider_pal_arb;
  localparam int unsigned AW = 11;
  localparam int unsigned DW = 16;

  logic          clk;
  logic          reset;
  logic          pixel_cen;
  logic [AW-1:0] pixel;
  logic [DW-1:0] vid_data;
  logic          vid_valid;
  logic          cpu_cs, cpu_we;
  logic [AW-1:0] cpu_addr;
  logic [DW-1:0] cpu_din;
  logic [1:0]    cpu_dsn;
  logic [DW-1:0] cpu_dout;
  logic          cpu_ok;
  logic [AW-1:0] ram_addr;
  logic [DW-1:0] ram_dout;
  logic [1:0]    ram_we;
  logic [DW-1:0] ram_din;

  int checks = 0;
  int errors = 0;

  batrider_pal_arb dut (
    .CLK(clk), .RESET(reset), .PIXEL_CEN(pixel_cen), .PIXEL(pixel),
    .VID_DATA(vid_data), .VID_VALID(vid_valid),
    .CPU_CS(cpu_cs), .CPU_WE(cpu_we), .CPU_ADDR(cpu_addr), .CPU_DIN(cpu_din),
    .CPU_DSN(cpu_dsn), .CPU_DOUT(cpu_dout), .CPU_OK(cpu_ok),
    .RAM_ADDR(ram_addr), .RAM_DOUT(ram_dout), .RAM_WE(ram_we), .RAM_DIN(ram_din)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Palette RAM model plus a log of every write seen on the port
  logic [DW-1:0] mem [2**AW];
  logic [AW-1:0] wr_log [$];
  logic [1:0]    we_log [$];
  always @(posedge clk) begin
    if (ram_we[1]) mem[ram_addr][15:8] <= ram_dout[15:8];
    if (ram_we[0]) mem[ram_addr][7:0]  <= ram_dout[7:0];
    if (ram_we != 2'b00) begin
      wr_log.push_back(ram_addr);
      we_log.push_back(ram_we);
    end
    ram_din <= mem[ram_addr];
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, time %0t", $time);
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Full CPU handshake; lat = cycles from CS rise to OK, or -1 on timeout
  task automatic cpu_access(input logic we, input logic [AW-1:0] a, input logic [DW-1:0] d,
                            input logic [1:0] dsn, output int lat, output logic [DW-1:0] dout);
    int n;
    lat = -1; dout = '0; n = 0;
    cpu_cs = 1'b1; cpu_we = we; cpu_addr = a; cpu_din = d; cpu_dsn = dsn;
    while (lat < 0 && n < 50) begin
      tick();
      n++;
      if (cpu_ok === 1'b1) begin lat = n; dout = cpu_dout; end
    end
    cpu_cs = 1'b0;
    tick();
  endtask

  task automatic test_reset();
    reset = 1'b1; pixel_cen = 1'b1; pixel = 11'h123;
    cpu_cs = 1'b0; cpu_we = 1'b0; cpu_addr = '0; cpu_din = '0; cpu_dsn = 2'b11;
    tick(); tick();
    checks++; if (ram_we !== 2'b00) begin errors++; $display("FAIL reset_ram_we: got %b expected 00", ram_we); end
    checks++; if (ram_addr !== 11'h000) begin errors++; $display("FAIL reset_ram_addr: got %h expected 000", ram_addr); end
    checks++; if (vid_valid !== 1'b0 || vid_data !== 16'h0000) begin errors++; $display("FAIL reset_vid: got %b/%h expected 0/0000", vid_valid, vid_data); end
    checks++; if (cpu_ok !== 1'b0 || cpu_dout !== 16'h0000) begin errors++; $display("FAIL reset_cpu: got %b/%h expected 0/0000", cpu_ok, cpu_dout); end
    reset = 1'b0; pixel_cen = 1'b0;
    tick();
  endtask

  task automatic test_video();
    int lat; logic [DW-1:0] d;
    cpu_access(1'b1, 11'h123, 16'h7FFF, 2'b00, lat, d);
    checks++; if (lat !== 1) begin errors++; $display("FAIL video_preload_lat: got %0d expected 1", lat); end
    repeat (3) tick();
    for (int k = 0; k < 3; k++) begin
      pixel_cen = 1'b1; pixel = 11'h123;
      #1;
      checks++; if (ram_addr !== 11'h123 || ram_we !== 2'b00) begin errors++; $display("FAIL video_port: got %h/%b expected 123/00", ram_addr, ram_we); end
      tick();
      pixel_cen = 1'b0;
      checks++; if (vid_valid !== 1'b0) begin errors++; $display("FAIL video_early_valid: got %b expected 0", vid_valid); end
      tick();
      checks++; if (vid_valid !== 1'b1 || vid_data !== 16'h7FFF) begin errors++; $display("FAIL video_data: got %b/%h expected 1/7fff", vid_valid, vid_data); end
      tick();
      checks++; if (vid_valid !== 1'b0) begin errors++; $display("FAIL video_pulse: got %b expected 0", vid_valid); end
      repeat (9) tick();
    end
  endtask

  task automatic test_cpu_write();
    int base;
    base = wr_log.size();
    cpu_cs = 1'b1; cpu_we = 1'b1; cpu_addr = 11'h010; cpu_din = 16'h5A5A; cpu_dsn = 2'b00;
    tick();
    checks++; if (cpu_ok !== 1'b1) begin errors++; $display("FAIL write_ok: got %b expected 1", cpu_ok); end
    cpu_cs = 1'b0;
    #1;
    checks++; if (ram_we !== 2'b11 || ram_addr !== 11'h010 || ram_dout !== 16'h5A5A) begin errors++; $display("FAIL write_drain: got %b/%h/%h expected 11/010/5a5a", ram_we, ram_addr, ram_dout); end
    tick();
    checks++; if (cpu_ok !== 1'b0) begin errors++; $display("FAIL write_ok_pulse: got %b expected 0", cpu_ok); end
    checks++; if (wr_log.size() !== base + 1 || mem[11'h010] !== 16'h5A5A) begin errors++; $display("FAIL write_ram: got %0d writes / %h expected %0d / 5a5a", wr_log.size() - base, mem[11'h010], 1); end
  endtask

  task automatic test_fifo_full();
    int lat, base; logic [DW-1:0] d; logic ok_seen;
    pixel_cen = 1'b1; pixel = 11'h123;
    base = wr_log.size();
    for (int i = 0; i < 4; i++) begin
      cpu_access(1'b1, AW'(11'h300 + i), DW'(16'h1000 + i), 2'b00, lat, d);
      checks++; if (lat !== 1) begin errors++; $display("FAIL full_accept%0d: got lat %0d expected 1", i, lat); end
    end
    cpu_cs = 1'b1; cpu_we = 1'b1; cpu_addr = 11'h304; cpu_din = 16'h1004; cpu_dsn = 2'b00;
    ok_seen = 1'b0;
    repeat (6) begin tick(); if (cpu_ok === 1'b1) ok_seen = 1'b1; end
    checks++; if (ok_seen !== 1'b0) begin errors++; $display("FAIL full_withheld: got ok %b expected 0", ok_seen); end
    pixel_cen = 1'b0;
    #1;
    checks++; if (ram_addr !== 11'h300 || ram_we !== 2'b11) begin errors++; $display("FAIL full_head: got %h/%b expected 300/11", ram_addr, ram_we); end
    tick();
    checks++; if (cpu_ok !== 1'b1) begin errors++; $display("FAIL full_fifth_ok: got %b expected 1", cpu_ok); end
    cpu_cs = 1'b0;
    repeat (8) tick();
    checks++; if (wr_log.size() !== base + 5) begin errors++; $display("FAIL full_count: got %0d expected 5", wr_log.size() - base); end
    for (int i = 0; i < 5; i++) begin
      checks++;
      if (wr_log.size() < base + 5 || wr_log[base + i] !== AW'(11'h300 + i) || mem[AW'(11'h300 + i)] !== DW'(16'h1000 + i)) begin
        errors++; $display("FAIL full_order%0d: got %h=%h expected %h=%h", i,
                           (wr_log.size() > base + i) ? wr_log[base + i] : 11'h7FF, mem[AW'(11'h300 + i)], AW'(11'h300 + i), DW'(16'h1000 + i));
      end
    end
  endtask

  task automatic test_read_after_write();
    int lat, base; logic [DW-1:0] d;
    base = wr_log.size();
    cpu_access(1'b1, 11'h200, 16'h1234, 2'b00, lat, d);
    cpu_access(1'b0, 11'h200, 16'h0000, 2'b00, lat, d);
`ifdef BATRIDER_PAL_CPU_RD_EN
    checks++; if (lat !== 4 || d !== 16'h1234) begin errors++; $display("FAIL raw_read: got lat %0d data %h expected 4 / 1234", lat, d); end
`else
    checks++; if (lat !== 1 || d !== 16'hFFFF) begin errors++; $display("FAIL raw_fill: got lat %0d data %h expected 1 / ffff", lat, d); end
`endif
    checks++; if (wr_log.size() !== base + 1 || mem[11'h200] !== 16'h1234) begin errors++; $display("FAIL raw_write_first: got %0d writes / %h expected 1 / 1234", wr_log.size() - base, mem[11'h200]); end
    base = wr_log.size();
    cpu_access(1'b1, 11'h201, 16'hDEAD, 2'b11, lat, d);
    repeat (3) tick();
    checks++; if (lat !== 1 || wr_log.size() !== base) begin errors++; $display("FAIL null_write: got lat %0d writes %0d expected 1 / 0", lat, wr_log.size() - base); end
  endtask

  task automatic test_byte_lane();
    int lat, base; logic [DW-1:0] d;
    cpu_access(1'b1, 11'h040, 16'h00CD, 2'b00, lat, d);
    base = we_log.size();
    cpu_access(1'b1, 11'h040, 16'hAB00, 2'b01, lat, d);
    tick();
    checks++; if (lat !== 1 || we_log.size() !== base + 1 || we_log[base] !== 2'b10) begin errors++; $display("FAIL byte_we: got lat %0d we %b expected 1 / 10", lat, (we_log.size() > base) ? we_log[base] : 2'b00); end
    checks++; if (mem[11'h040] !== 16'hABCD) begin errors++; $display("FAIL byte_ram: got %h expected abcd", mem[11'h040]); end
    cpu_access(1'b0, 11'h040, 16'h0000, 2'b00, lat, d);
`ifdef BATRIDER_PAL_CPU_RD_EN
    checks++; if (d !== 16'hABCD) begin errors++; $display("FAIL byte_readback: got %h expected abcd", d); end
`else
    checks++; if (d !== 16'hFFFF) begin errors++; $display("FAIL byte_readfill: got %h expected ffff", d); end
`endif
  endtask

  task automatic test_reset_mid_read();
    int lat, base; logic [DW-1:0] d;
    pixel_cen = 1'b1; pixel = 11'h123;
    cpu_access(1'b1, 11'h060, 16'h0AAA, 2'b00, lat, d);
    cpu_access(1'b1, 11'h061, 16'h0BBB, 2'b00, lat, d);
    cpu_cs = 1'b1; cpu_we = 1'b0; cpu_addr = 11'h060;
`ifdef BATRIDER_PAL_CPU_RD_EN
    tick(); tick();
`endif
    reset = 1'b1;
    #1;
    checks++; if (ram_we !== 2'b00 || ram_addr !== 11'h000) begin errors++; $display("FAIL rst_ram: got %b/%h expected 00/000", ram_we, ram_addr); end
    tick();
    reset = 1'b0; cpu_cs = 1'b0; pixel_cen = 1'b0;
    #1;
    checks++; if (cpu_ok !== 1'b0 || cpu_dout !== 16'h0000) begin errors++; $display("FAIL rst_cpu: got %b/%h expected 0/0000", cpu_ok, cpu_dout); end
    checks++; if (vid_valid !== 1'b0 || vid_data !== 16'h0000) begin errors++; $display("FAIL rst_vid: got %b/%h expected 0/0000", vid_valid, vid_data); end
    base = wr_log.size();
    repeat (4) begin
      tick();
      if (cpu_ok === 1'b1) begin checks++; errors++; $display("FAIL rst_stray_ok: got 1 expected 0"); end
    end
    checks++; if (wr_log.size() !== base) begin errors++; $display("FAIL rst_fifo_empty: got %0d writes expected 0", wr_log.size() - base); end
    cpu_access(1'b1, 11'h062, 16'h0777, 2'b00, lat, d);
    tick();
    checks++; if (lat !== 1 || wr_log.size() !== base + 1 || wr_log[base] !== 11'h062 || mem[11'h062] !== 16'h0777) begin
      errors++; $display("FAIL rst_next_write: got lat %0d writes %0d data %h expected 1 / 1 / 0777", lat, wr_log.size() - base, mem[11'h062]);
    end
  endtask

  initial begin
    test_reset();
    test_video();
    test_cpu_write();
    test_fifo_full();
    test_read_after_write();
    test_byte_lane();
    test_reset_mid_read();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
